ctrl_sched: RTL and testbench
=============================

Name: ctrl_sched

Overview:
- Frame sequencer that drives a ctrl_bus-style start/valid/stop triple into a downstream datapath, e.g. a PE array or pooling unit.
- Runs a job of n_frame frames, each of n_beat valid beats.
- Honours a stall input; waits for a per-frame downstream completion before starting the next frame.
- Sits between the layer-level controller and the datapath control inputs.

Parameters:
- CNT_W, 16: width of the beat and frame counters and limits.
- DELAY, 3: pipeline depth of the optional delayed control copy (used only with CTRL_SCHED_DELAY_EN); minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- xrst  input  1  asynchronous active-low reset.
- req  input  1  job start pulse; sampled in IDLE only.
- n_beat  input  CNT_W  beats per frame; latched on accepted req.
- n_frame  input  CNT_W  frames per job; latched on accepted req.
- stall  input  1  suppresses valid beats while high in RUN.
- ack_done  input  1  downstream frame-complete pulse.
- out_start  output  1  ctrl start, one-cycle pulse per frame.
- out_valid  output  1  ctrl valid, one per beat.
- out_stop  output  1  ctrl stop, one-cycle pulse per frame.
- beat_idx  output  CNT_W  index of the current beat, 0-based.
- frame_idx  output  CNT_W  index of the current frame, 0-based.
- busy  output  1  high from accepted req until the DONE cycle, inclusive.
- done  output  1  one-cycle job-complete pulse.
- out_start_d, out_valid_d, out_stop_d  output  1 each  DELAY-cycle copies; present only with CTRL_SCHED_DELAY_EN.

Behaviour:
- All outputs are registered. Reset value of every output and counter is 0; state resets to IDLE.
- Reset asserted mid-job aborts immediately. No stop is emitted.
- FSM states: IDLE, START, RUN, STOP, WAIT, DONE.
- IDLE:
  - req with n_beat!=0 and n_frame!=0: latch both limits, clear counters, go to START.
  - req with either limit 0: go to DONE. No start/valid/stop is emitted.
  - req outside IDLE is ignored.
- START: out_start=1 for exactly one cycle; clear the ack flag; go to RUN.
- Latency: req at edge t gives out_start high in cycle t+1 and first out_valid no earlier than t+2.
- RUN:
  - out_valid=1 in each cycle stall=0; out_valid=0 while stall=1.
  - beat_idx increments after each valid beat.
  - On the valid beat with beat_idx==n_beat-1, go to STOP and reset beat_idx to 0.
  - A stall on the last beat holds RUN.
- STOP: out_stop=1 for one cycle; go to WAIT.
- Ack flag: sticky; set by ack_done high in the STOP or WAIT cycle. ack_done in any other state is ignored.
- WAIT:
  - No control outputs are asserted.
  - When the ack flag is set or ack_done=1: if frame_idx==n_frame-1, go to DONE; otherwise increment frame_idx and go to START.
  - ack_done and the state change may coincide; no extra cycle is inserted.
- DONE: done=1 and busy=1 for one cycle; frame_idx returns to 0; go to IDLE.
- A req arriving in the same cycle DONE is left is ignored.
- out_start, out_valid and out_stop are mutually exclusive in every cycle.
- Counters compare against the latched limits, never the live inputs.
- n_beat=2^CNT_W-1 is legal. The counters never wrap inside a frame.

Optional Feature:
- Macro: CTRL_SCHED_DELAY_EN.
- When defined: the *_d ports exist. They carry {start,valid,stop} delayed by exactly DELAY cycles through a reset-to-0 shift register. This matches datapath pipeline depth, e.g. for a downstream accumulator.
- When undefined: the *_d ports and the delay logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package ctrl_pkg:
  - state enum type ctrl_sched_state_e.
  - default CNT_W constant.
  - packed 3-bit control struct (start, valid, stop), used by the delay line.
- One sub-module: ctrl_delay (parameter DELAY; in/out of that struct; clk/xrst).
  - Instantiated only under CTRL_SCHED_DELAY_EN.
  - Reusable elsewhere for aligning control to pipelined datapaths.

Test Plan:
- Basic job: n_beat=4, n_frame=2, no stall, ack_done 2 cycles after each stop.
  - Per frame: start, 4 valids (beat_idx 0..3), stop.
  - frame_idx 0 then 1; done once; busy for 19 cycles.
- Stall: n_beat=3, n_frame=1, stall high for 2 cycles at beat 1 and on the last beat.
  - Exactly 3 valids; no valid during stall; stop follows the final unstalled beat.
- Zero limits: req with n_beat=0, n_frame=5 → no start/valid/stop; done one cycle later; busy for 1 cycle.
- Ack timing:
  - ack_done during STOP → next start 2 cycles after stop.
  - ack_done during RUN only → scheduler waits in WAIT until a later ack.
- Reset and re-req:
  - xrst low during RUN of frame 1 of 3 → all outputs 0 at once; a later req restarts at frame_idx 0.
  - req while busy → ignored.
- CTRL_SCHED_DELAY_EN, DELAY=3: each *_d signal equals its undelayed twin shifted 3 cycles for the whole basic-job run; all 0 after reset.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the control scheduler: FSM state encoding, default counter
// width and the packed {start, valid, stop} control word.
package ctrl_pkg;

  localparam int CTRL_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_STOP  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } ctrl_sched_state_e;

  typedef struct packed {
    logic start;
    logic valid;
    logic stop;
  } ctrl_t;

endpackage

// File: rtl/ctrl_delay.sv
// Fixed-depth shift register that delays a control word by DELAY cycles so it
// lines up with a pipelined datapath. DELAY must be at least 1.
module ctrl_delay
  import ctrl_pkg::*;
#(
  parameter int DELAY = 3
) (
  input  logic  clk,
  input  logic  xrst,
  input  ctrl_t d,
  output ctrl_t q
);

  ctrl_t pipe [DELAY];

  // NOTE: this array is reset like any other flop; stale control bits must never leak out after a reset.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DELAY-1];

endmodule

// File: rtl/ctrl_sched.sv
// Frame sequencer: drives start/valid/stop for n_frame frames of n_beat beats,
// honouring stall and waiting for a per-frame ack. Optional delayed control
// copies are built when CTRL_SCHED_DELAY_EN is defined.
module ctrl_sched
  import ctrl_pkg::*;
#(
  parameter int CNT_W = CTRL_CNT_W,
  parameter int DELAY = 3
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic             req,
  input  logic [CNT_W-1:0] n_beat,
  input  logic [CNT_W-1:0] n_frame,
  input  logic             stall,
  input  logic             ack_done,
  output logic             out_start,
  output logic             out_valid,
  output logic             out_stop,
  output logic [CNT_W-1:0] beat_idx,
  output logic [CNT_W-1:0] frame_idx,
  output logic             busy,
  output logic             done
`ifdef CTRL_SCHED_DELAY_EN
  ,
  output logic             out_start_d,
  output logic             out_valid_d,
  output logic             out_stop_d
`endif
);

  ctrl_sched_state_e state, state_n;
  logic [CNT_W-1:0]  lim_beat, lim_beat_n;
  logic [CNT_W-1:0]  lim_frame, lim_frame_n;
  logic [CNT_W-1:0]  beat_n, frame_n;
  logic              ack_flag, ack_n;
  logic              start_n, valid_n, stop_n, busy_n, done_n;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n     = state;
    lim_beat_n  = lim_beat;
    lim_frame_n = lim_frame;
    beat_n      = beat_idx;
    frame_n     = frame_idx;
    ack_n       = ack_flag;

    unique case (state)
      ST_IDLE: begin
        if (req) begin
          if (n_beat != '0 && n_frame != '0) begin
            lim_beat_n  = n_beat;
            lim_frame_n = n_frame;
            beat_n      = '0;
            frame_n     = '0;
            state_n     = ST_START;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_START: begin
        ack_n   = 1'b0;
        state_n = ST_RUN;
      end
      ST_RUN: begin
        // A beat is the cycle out_valid is high; beat_idx names that beat.
        if (out_valid) begin
          if (beat_idx == lim_beat - CNT_W'(1)) begin
            beat_n  = '0;
            state_n = ST_STOP;
          end else begin
            beat_n = beat_idx + CNT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (ack_done) ack_n = 1'b1;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack_done) ack_n = 1'b1;
        if (ack_flag || ack_done) begin
          if (frame_idx == lim_frame - CNT_W'(1)) begin
            frame_n = '0;
            state_n = ST_DONE;
          end else begin
            frame_n = frame_idx + CNT_W'(1);
            state_n = ST_START;
          end
        end
      end
      ST_DONE: begin
        frame_n = '0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // Outputs are registered from the next state; stall therefore gates the
    // beat of the following cycle.
    start_n = (state_n == ST_START);
    valid_n = (state_n == ST_RUN) && !stall;
    stop_n  = (state_n == ST_STOP);
    busy_n  = (state_n != ST_IDLE);
    done_n  = (state_n == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state     <= ST_IDLE;
      lim_beat  <= '0;
      lim_frame <= '0;
      beat_idx  <= '0;
      frame_idx <= '0;
      ack_flag  <= 1'b0;
      out_start <= 1'b0;
      out_valid <= 1'b0;
      out_stop  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      lim_beat  <= lim_beat_n;
      lim_frame <= lim_frame_n;
      beat_idx  <= beat_n;
      frame_idx <= frame_n;
      ack_flag  <= ack_n;
      out_start <= start_n;
      out_valid <= valid_n;
      out_stop  <= stop_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

`ifdef CTRL_SCHED_DELAY_EN
  ctrl_t ctrl_now, ctrl_dly;

  assign ctrl_now = {out_start, out_valid, out_stop};

  ctrl_delay #(.DELAY(DELAY)) u_delay (
    .clk  (clk),
    .xrst (xrst),
    .d    (ctrl_now),
    .q    (ctrl_dly)
  );

  assign out_start_d = ctrl_dly.start;
  assign out_valid_d = ctrl_dly.valid;
  assign out_stop_d  = ctrl_dly.stop;
`else
  logic unused_delay;
  assign unused_delay = (DELAY > 0);
`endif

endmodule

// File: tb/tb_ctrl_sched.sv
// Directed bench for ctrl_sched: fixed jobs with hand-computed per-cycle
// start/valid/stop/busy/done patterns (bit c of each mask = cycle c after req).
module tb_ctrl_sched;
  import ctrl_pkg::*;

  localparam int CNT_W = 16;
  localparam int DELAY = 3;

  logic             clk = 1'b0;
  logic             xrst = 1'b0;
  logic             req = 1'b0;
  logic             stall = 1'b0;
  logic             ack_done = 1'b0;
  logic [CNT_W-1:0] n_beat = '0;
  logic [CNT_W-1:0] n_frame = '0;
  logic             out_start, out_valid, out_stop, busy, done;
  logic [CNT_W-1:0] beat_idx, frame_idx;
`ifdef CTRL_SCHED_DELAY_EN
  logic             out_start_d, out_valid_d, out_stop_d;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] r_start, r_valid, r_stop, r_busy, r_done;
  logic [63:0] r_sd, r_vd, r_pd;
  int          rb [64];
  int          rf [64];

  always #5 clk = ~clk;

  ctrl_sched #(.CNT_W(CNT_W), .DELAY(DELAY)) dut (
    .clk       (clk),
    .xrst      (xrst),
    .req       (req),
    .n_beat    (n_beat),
    .n_frame   (n_frame),
    .stall     (stall),
    .ack_done  (ack_done),
    .out_start (out_start),
    .out_valid (out_valid),
    .out_stop  (out_stop),
    .beat_idx  (beat_idx),
    .frame_idx (frame_idx),
    .busy      (busy),
    .done      (done)
`ifdef CTRL_SCHED_DELAY_EN
    ,
    .out_start_d (out_start_d),
    .out_valid_d (out_valid_d),
    .out_stop_d  (out_stop_d)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bits(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Called at posedge+1; drives cycle c inputs and records cycle c outputs.
  // Limits are only valid in cycle 0; other cycles carry decoy values.
  task automatic run(input logic [15:0] nb, input logic [15:0] nf,
                     input logic [63:0] req_v, input logic [63:0] stall_v,
                     input logic [63:0] ack_v, input int ncyc);
    r_start = '0; r_valid = '0; r_stop = '0; r_busy = '0; r_done = '0;
    r_sd = '0; r_vd = '0; r_pd = '0;
    for (int c = 0; c < ncyc; c++) begin
      req      = req_v[c];
      stall    = stall_v[c];
      ack_done = ack_v[c];
      n_beat   = (c == 0) ? nb : 16'd7;
      n_frame  = (c == 0) ? nf : 16'd7;
      r_start[c] = out_start;
      r_valid[c] = out_valid;
      r_stop[c]  = out_stop;
      r_busy[c]  = busy;
      r_done[c]  = done;
      rb[c] = int'(beat_idx);
      rf[c] = int'(frame_idx);
`ifdef CTRL_SCHED_DELAY_EN
      r_sd[c] = out_start_d;
      r_vd[c] = out_valid_d;
      r_pd[c] = out_stop_d;
`endif
      @(posedge clk); #1;
    end
    req = 1'b0; stall = 1'b0; ack_done = 1'b0;
  endtask

  task automatic check_job(input string t, input logic [63:0] s, input logic [63:0] v,
                           input logic [63:0] p, input logic [63:0] b, input logic [63:0] d);
    check({t, ".start"}, r_start, s);
    check({t, ".valid"}, r_valid, v);
    check({t, ".stop"},  r_stop,  p);
    check({t, ".busy"},  r_busy,  b);
    check({t, ".done"},  r_done,  d);
  endtask

  task automatic check_idle_outputs(input string t);
    check({t, ".ctrl"}, {61'd0, out_start, out_valid, out_stop}, 64'd0);
    check({t, ".stat"}, {62'd0, busy, done}, 64'd0);
    check({t, ".idx"},  {32'd0, beat_idx, frame_idx}, 64'd0);
`ifdef CTRL_SCHED_DELAY_EN
    check({t, ".ctrl_d"}, {61'd0, out_start_d, out_valid_d, out_stop_d}, 64'd0);
`endif
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset.asserted");
    #2 xrst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset.released");

    // Basic job: 4 beats x 2 frames, ack with two idle cycles after each stop.
    run(16'd4, 16'd2, 64'd1, 64'd0, (64'd1 << 9) | (64'd1 << 18), 24);
    check_job("basic",
              (64'd1 << 1) | (64'd1 << 10),
              bits(2, 5) | bits(11, 14),
              (64'd1 << 6) | (64'd1 << 15),
              bits(1, 19),
              64'd1 << 19);
    for (int i = 0; i < 4; i++) begin
      check("basic.beat_f0", rb[2 + i], i);
      check("basic.beat_f1", rb[11 + i], i);
    end
    check("basic.beat_after_stop", rb[6], 0);
    check("basic.frame0", rf[5], 0);
    check("basic.frame1", rf[15], 1);
    check("basic.frame_idle", rf[20], 0);
`ifdef CTRL_SCHED_DELAY_EN
    check("basic.start_d", r_sd, ((64'd1 << 1) | (64'd1 << 10)) << 3);
    check("basic.valid_d", r_vd, (bits(2, 5) | bits(11, 14)) << 3);
    check("basic.stop_d",  r_pd, ((64'd1 << 6) | (64'd1 << 15)) << 3);
`endif

    // Stall: stall during cycles 2,3 and 5 removes the beats of cycles 3,4 and 6.
    run(16'd3, 16'd1, 64'd1, (64'd1 << 2) | (64'd1 << 3) | (64'd1 << 5), 64'd1 << 9, 14);
    check_job("stall",
              64'd1 << 1,
              (64'd1 << 2) | (64'd1 << 5) | (64'd1 << 7),
              64'd1 << 8,
              bits(1, 10),
              64'd1 << 10);
    check("stall.beat1", rb[5], 1);
    check("stall.beat2", rb[7], 2);

    // Zero limit: straight to DONE, no control pulses.
    run(16'd0, 16'd5, 64'd1, 64'd0, 64'd0, 6);
    check_job("zero", 64'd0, 64'd0, 64'd0, 64'd1 << 1, 64'd1 << 1);

    // Ack timing: ack in STOP (frame 0), ack only in RUN then late ack (frame 1);
    // req while busy (cycle 8) and in the DONE cycle (cycle 14) are ignored.
    run(16'd2, 16'd2, (64'd1 << 0) | (64'd1 << 8) | (64'd1 << 14), 64'd0,
        (64'd1 << 4) | (64'd1 << 7) | (64'd1 << 13), 20);
    check_job("ack",
              (64'd1 << 1) | (64'd1 << 6),
              bits(2, 3) | bits(7, 8),
              (64'd1 << 4) | (64'd1 << 9),
              bits(1, 14),
              64'd1 << 14);
    check("ack.frame1", rf[7], 1);

    // Reset mid-job during RUN of frame 1 of 3.
    run(16'd4, 16'd3, 64'd1, 64'd0, 64'd1 << 7, 10);
    check_job("abort",
              (64'd1 << 1) | (64'd1 << 8),
              bits(2, 5) | (64'd1 << 9),
              64'd1 << 6,
              bits(1, 9),
              64'd0);
    check("abort.frame_before", rf[9], 1);
    xrst = 1'b0;
    #1;
    check_idle_outputs("abort.reset");
    #2 xrst = 1'b1;
    @(posedge clk); #1;

    // Restart after reset begins again at frame 0.
    run(16'd1, 16'd1, 64'd1, 64'd0, 64'd1 << 4, 8);
    check_job("restart", 64'd1 << 1, 64'd1 << 2, 64'd1 << 3, bits(1, 5), 64'd1 << 5);
    check("restart.frame", rf[2], 0);
    check("restart.beat", rb[2], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
